// File: rtl/tls_monitor.sv
// Passive observer of the traffic-light controller lamp interface: rebuilds each
// completed phase and checks lamp encoding, phase order and phase duration.
module tls_monitor #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_obs,
  input  logic             stop_obs,
  input  logic             jump_obs,
  input  logic [3:0]       g_dur,
  input  logic [3:0]       y_dur,
  input  logic [3:0]       r_dur,
  input  logic             g_lamp,
  input  logic             y_lamp,
  input  logic             r_lamp,
  output logic             phase_done,
  output logic [1:0]       phase_id,
  output logic [CNT_W-1:0] phase_len,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             dur_err,
  output logic             err_any
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  localparam logic [1:0]       PH_G    = 2'd0;
  localparam logic [1:0]       PH_Y    = 2'd1;
  localparam logic [1:0]       PH_R    = 2'd2;
  localparam logic [1:0]       PH_BAD  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Lamp code {g,y,r} to phase id; anything not strictly one-hot maps to PH_BAD.
  function automatic logic [1:0] lamp_id(input logic [2:0] code);
    case (code)
      3'b100:  lamp_id = PH_G;
      3'b010:  lamp_id = PH_Y;
      3'b001:  lamp_id = PH_R;
      default: lamp_id = PH_BAD;
    endcase
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] id);
    case (id)
      PH_G:    next_phase = PH_Y;
      PH_Y:    next_phase = PH_R;
      PH_R:    next_phase = PH_G;
      default: next_phase = PH_G;
    endcase
  endfunction

  // A programmed duration of zero means the controller runs the full 16 ticks.
  function automatic logic [4:0] exp_len(input logic [3:0] dur);
    exp_len = (dur == 4'd0) ? 5'd16 : {1'b0, dur};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    sat_inc = (en && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             prev_valid_q;
  logic [1:0]       prev_id_q;
  logic             exp_valid_q;
  logic [4:0]       exp_g_q, exp_y_q, exp_r_q;

  logic             done_d, oh_d, seq_d, dur_d;
  logic [1:0]       id_d;
  logic [CNT_W-1:0] len_d;

  logic [1:0]       samp_id_s;
  logic             legal_s;
  logic             force_g_s, force_r_s, force_s, stall_s;
  logic [1:0]       force_id_s;
  logic [4:0]       exp_cur_s;

  assign samp_id_s  = lamp_id({g_lamp, y_lamp, r_lamp});
  assign legal_s    = (samp_id_s != PH_BAD);
  assign force_g_s  = set_obs;
  assign stall_s    = stop_obs & ~set_obs;
  assign force_r_s  = jump_obs & ~set_obs & ~stop_obs;
  assign force_s    = force_g_s | force_r_s;
  assign force_id_s = force_g_s ? PH_G : PH_R;

  // Programmed length of the phase currently being tracked.
  always_comb begin
    case (cur_q)
      PH_G:    exp_cur_s = exp_g_q;
      PH_Y:    exp_cur_s = exp_y_q;
      PH_R:    exp_cur_s = exp_r_q;
      default: exp_cur_s = exp_g_q;
    endcase
  end

  // Phase tracker next state and per-sample report.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    run_d   = run_q;
    stall_d = stall_q;
    done_d  = 1'b0;
    id_d    = 2'd0;
    len_d   = '0;
    oh_d    = 1'b0;
    seq_d   = 1'b0;
    dur_d   = 1'b0;
    if (!legal_s) begin
      oh_d    = 1'b1;
      state_d = ST_SYNC;
    end else begin
      case (state_q)
        ST_SYNC: begin
          // A force gives a trusted phase start once the forced lamp shows up.
          if (force_s) begin
            cur_d   = force_id_s;
            run_d   = '0;
            stall_d = '0;
            state_d = ST_PEND;
          end else if (prev_valid_q && (samp_id_s != prev_id_q)) begin
            cur_d   = samp_id_s;
            run_d   = CNT_ONE;
            stall_d = '0;
            state_d = ST_TRACK;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_TRACK: begin
          if (force_s) begin
            done_d  = 1'b1;
            id_d    = cur_q;
            len_d   = sat_inc(run_q, 1'b1);
            cur_d   = force_id_s;
            run_d   = '0;
            stall_d = '0;
            state_d = ST_PEND;
          end else if (samp_id_s == cur_q) begin
            run_d   = sat_inc(run_q, 1'b1);
            stall_d = sat_inc(stall_q, stall_s);
          end else begin
            done_d = 1'b1;
            id_d   = cur_q;
            len_d  = run_q;
            if (samp_id_s != next_phase(cur_q)) begin
              seq_d = 1'b1;
            end else if (exp_valid_q && (run_q != CNT_MAX) && (stall_q != CNT_MAX)) begin
              dur_d = ((run_q - stall_q) != CNT_W'(exp_cur_s));
            end else begin
              dur_d = 1'b0;
            end
            cur_d   = samp_id_s;
            run_d   = CNT_ONE;
            stall_d = '0;
          end
        end
        ST_PEND: begin
          if (force_s) begin
            cur_d   = force_id_s;
            run_d   = '0;
            stall_d = '0;
          end else if (samp_id_s == cur_q) begin
            run_d   = CNT_ONE;
            stall_d = '0;
            state_d = ST_TRACK;
          end else begin
            seq_d   = 1'b1;
            state_d = ST_SYNC;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  // Tracker state, sample history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      cur_q        <= PH_G;
      run_q        <= '0;
      stall_q      <= '0;
      prev_valid_q <= 1'b0;
      prev_id_q    <= PH_G;
      phase_done   <= 1'b0;
      phase_id     <= 2'd0;
      phase_len    <= '0;
      onehot_err   <= 1'b0;
      seq_err      <= 1'b0;
      dur_err      <= 1'b0;
      err_any      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      run_q        <= run_d;
      stall_q      <= stall_d;
      prev_valid_q <= legal_s;
      prev_id_q    <= samp_id_s;
      phase_done   <= done_d;
      phase_id     <= id_d;
      phase_len    <= len_d;
      onehot_err   <= oh_d;
      seq_err      <= seq_d;
      dur_err      <= dur_d;
      err_any      <= err_any | oh_d | seq_d | dur_d;
    end
  end

  // Programmed durations, captured whenever the controller sees Set.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_valid_q <= 1'b0;
      exp_g_q     <= 5'd0;
      exp_y_q     <= 5'd0;
      exp_r_q     <= 5'd0;
    end else if (set_obs) begin
      exp_valid_q <= 1'b1;
      exp_g_q     <= exp_len(g_dur);
      exp_y_q     <= exp_len(y_dur);
      exp_r_q     <= exp_len(r_dur);
    end else begin
      exp_valid_q <= exp_valid_q;
      exp_g_q     <= exp_g_q;
      exp_y_q     <= exp_y_q;
      exp_r_q     <= exp_r_q;
    end
  end

endmodule

// File: tb/tb_tls_monitor.sv
// Directed bench for tls_monitor: lamp/command stream per cycle, expected
// outputs queued at drive time and compared one cycle later.
module tb_tls_monitor;
  localparam int CNT_W = 6;
  localparam logic [2:0] LG   = 3'b100;
  localparam logic [2:0] LY   = 3'b010;
  localparam logic [2:0] LR   = 3'b001;
  localparam logic [2:0] LBAD = 3'b110;

  logic             clk = 1'b0;
  logic             reset;
  logic             set_obs, stop_obs, jump_obs;
  logic [3:0]       g_dur, y_dur, r_dur;
  logic             g_lamp, y_lamp, r_lamp;
  logic             phase_done;
  logic [1:0]       phase_id;
  logic [CNT_W-1:0] phase_len;
  logic             onehot_err, seq_err, dur_err, err_any;

  typedef struct packed {
    logic             done;
    logic [1:0]       id;
    logic [CNT_W-1:0] len;
    logic             oh;
    logic             seq;
    logic             dur;
    logic             any;
    logic             rst;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic sticky = 1'b0;

  tls_monitor #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .set_obs(set_obs), .stop_obs(stop_obs), .jump_obs(jump_obs),
    .g_dur(g_dur), .y_dur(y_dur), .r_dur(r_dur),
    .g_lamp(g_lamp), .y_lamp(y_lamp), .r_lamp(r_lamp),
    .phase_done(phase_done), .phase_id(phase_id), .phase_len(phase_len),
    .onehot_err(onehot_err), .seq_err(seq_err), .dur_err(dur_err),
    .err_any(err_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: observed %0d entries expected >0", sb_q.size());
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("phase_done", 32'(phase_done), 32'(e.done));
      if (e.done || e.rst) begin
        chk("phase_id", 32'(phase_id), 32'(e.id));
        chk("phase_len", 32'(phase_len), 32'(e.len));
      end
      chk("onehot_err", 32'(onehot_err), 32'(e.oh));
      chk("seq_err", 32'(seq_err), 32'(e.seq));
      chk("dur_err", 32'(dur_err), 32'(e.dur));
      chk("err_any", 32'(err_any), 32'(e.any));
    end
  endtask

  task automatic step(input logic [2:0] lamp, input logic s, input logic st, input logic j,
                      input logic e_done, input logic [1:0] e_id, input int e_len,
                      input logic e_seq, input logic e_dur);
    exp_t e;
    {g_lamp, y_lamp, r_lamp} = lamp;
    set_obs  = s;
    stop_obs = st;
    jump_obs = j;
    e.done = e_done;
    e.id   = e_id;
    e.len  = CNT_W'(e_len);
    e.oh   = !(lamp == LG || lamp == LY || lamp == LR);
    e.seq  = e_seq;
    e.dur  = e_dur;
    sticky = sticky | e.oh | e_seq | e_dur;
    e.any  = sticky;
    e.rst  = 1'b0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
  endtask

  task automatic idle(input logic [2:0] lamp, input int n);
    for (int i = 0; i < n; i++) step(lamp, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
  endtask

  task automatic rep(input logic [2:0] lamp, input logic [1:0] id, input int len,
                     input logic e_seq, input logic e_dur);
    step(lamp, 1'b0, 1'b0, 1'b0, 1'b1, id, len, e_seq, e_dur);
  endtask

  task automatic do_reset();
    exp_t e;
    reset  = 1'b1;
    sticky = 1'b0;
    e      = '0;
    e.rst  = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_obs = 1'b0; stop_obs = 1'b0; jump_obs = 1'b0;
    g_dur = 4'd0; y_dur = 4'd0; r_dur = 4'd0;
    {g_lamp, y_lamp, r_lamp} = LR;
    @(negedge clk);
    do_reset();

    // 1: programmed 3/2/4, free run
    g_dur = 4'd3; y_dur = 4'd2; r_dur = 4'd4;
    step(LR, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
    idle(LG, 3);
    rep(LY, 2'd0, 3, 1'b0, 1'b0); idle(LY, 1);
    rep(LR, 2'd1, 2, 1'b0, 1'b0); idle(LR, 3);
    rep(LG, 2'd2, 4, 1'b0, 1'b0); idle(LG, 2);
    rep(LY, 2'd0, 3, 1'b0, 1'b0); idle(LY, 1);

    // 2: two stalled cycles inside green
    rep(LR, 2'd1, 2, 1'b0, 1'b0); idle(LR, 3);
    rep(LG, 2'd2, 4, 1'b0, 1'b0);
    step(LG, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
    step(LG, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
    idle(LG, 2);
    rep(LY, 2'd0, 5, 1'b0, 1'b0); idle(LY, 1);
    rep(LR, 2'd1, 2, 1'b0, 1'b0); idle(LR, 3);

    // 3: re-Set (red cut at 5, no dur check), then jump cuts yellow at 3 of 4
    y_dur = 4'd4;
    step(LR, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 5, 1'b0, 1'b0);
    idle(LG, 3);
    rep(LY, 2'd0, 3, 1'b0, 1'b0); idle(LY, 1);
    step(LY, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 3, 1'b0, 1'b0);
    idle(LR, 4);
    rep(LG, 2'd2, 4, 1'b0, 1'b0);

    // 4: illegal lamp code, resync on next clean change
    idle(LG, 1);
    step(LBAD, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 1'b0);
    idle(LG, 2);
    idle(LY, 4);
    rep(LR, 2'd1, 4, 1'b0, 1'b0);

    // 5: R->Y out of order, then an over-long green
    idle(LR, 3);
    rep(LY, 2'd2, 4, 1'b1, 1'b0); idle(LY, 3);
    rep(LR, 2'd1, 4, 1'b0, 1'b0); idle(LR, 3);
    rep(LG, 2'd2, 4, 1'b0, 1'b0); idle(LG, 4);
    rep(LY, 2'd0, 5, 1'b0, 1'b1);

    // 6: G=0 means 16 ticks; then reset mid-red
    g_dur = 4'd0; y_dur = 4'd2; r_dur = 4'd4;
    step(LY, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2, 1'b0, 1'b0);
    idle(LG, 16);
    rep(LY, 2'd0, 16, 1'b0, 1'b0); idle(LY, 1);
    rep(LR, 2'd1, 2, 1'b0, 1'b0); idle(LR, 2);
    do_reset();
    idle(LR, 3);
    idle(LG, 4);
    rep(LY, 2'd0, 4, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
